// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned XLEN_ITER = 64;
  localparam int unsigned WORD_ITER = 32;

  typedef enum logic [2:0] {
    OpMul    = 3'd0,
    OpMulh   = 3'd1,
    OpMulhsu = 3'd2,
    OpMulhu  = 3'd3,
    OpDiv    = 3'd4,
    OpDivu   = 3'd5,
    OpRem    = 3'd6,
    OpRemu   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_iter_dp.sv
// Radix-2 shift-add / restoring-subtract datapath: {hi,lo} accumulator and one adder.
// Optional MULDIV_EARLY_OUT_EN: skip the remaining multiply iterations once the
// unconsumed multiplier bits are all zero.
module muldiv_iter_dp
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_ITER,
  parameter int unsigned CNT_W = 7
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [XLEN-1:0]  i_load_lo,
  input  logic [XLEN-1:0]  i_load_opnd,
  input  logic             i_step,
  input  logic             i_is_mul,
  input  logic [CNT_W-1:0] i_shamt,
  output logic             o_skip,
  output logic [XLEN-1:0]  o_next_hi,
  output logic [XLEN-1:0]  o_next_lo
);

  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_opnd;
  logic [XLEN:0]     w_add_a;
  logic [XLEN:0]     w_add_b;
  logic              w_cin;
  logic [XLEN+1:0]   w_sum;
  logic [2*XLEN-1:0] w_shifted;

  // Shared adder: multiply adds the multiplicand, divide subtracts the divisor.
  always_comb begin
    w_add_a = i_is_mul ? {1'b0, r_hi} : {r_hi, r_lo[XLEN-1]};
    w_add_b = i_is_mul ? (r_lo[0] ? {1'b0, r_opnd} : '0) : ~{1'b0, r_opnd};
    w_cin   = ~i_is_mul;
    w_sum   = {1'b0, w_add_a} + {1'b0, w_add_b} + {{(XLEN+1){1'b0}}, w_cin};
  end

  assign w_shifted = {r_hi, r_lo} >> i_shamt;

`ifdef MULDIV_EARLY_OUT_EN
  logic [XLEN-1:0] w_mask;
  // Multiplier bits still to be consumed sit in lo[cnt-1:0].
  assign w_mask = (XLEN'(1) << i_shamt) - XLEN'(1);
  assign o_skip = i_step & i_is_mul & ((r_lo & w_mask) == '0);
`else
  assign o_skip = 1'b0;
`endif

  // Next accumulator value for one iteration (or the early-out jump).
  always_comb begin
    if (o_skip) begin
      {o_next_hi, o_next_lo} = w_shifted;
    end else if (i_is_mul) begin
      o_next_hi = w_sum[XLEN:1];
      o_next_lo = {w_sum[0], r_lo[XLEN-1:1]};
    end else if (w_sum[XLEN+1]) begin
      // No borrow: partial remainder >= divisor.
      o_next_hi = w_sum[XLEN-1:0];
      o_next_lo = {r_lo[XLEN-2:0], 1'b1};
    end else begin
      o_next_hi = w_add_a[XLEN-1:0];
      o_next_lo = {r_lo[XLEN-2:0], 1'b0};
    end
  end

  // Accumulator and operand registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_opnd <= '0;
    end else if (i_load) begin
      r_hi   <= '0;
      r_lo   <= i_load_lo;
      r_opnd <= i_load_opnd;
    end else if (i_step) begin
      r_hi   <= o_next_hi;
      r_lo   <= o_next_lo;
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequencer for the shared iterative M-extension unit: FSM, counter,
// fast-case detection and sign/word fix-up. Optional macro: MULDIV_EARLY_OUT_EN.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 7
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_req_valid,
  input  logic [2:0]      i_req_op,
  input  logic            i_req_word,
  input  logic [XLEN-1:0] i_srca,
  input  logic [XLEN-1:0] i_srcb,
  input  logic            i_flush,
  input  logic            i_resp_ready,
  output logic            o_stall_out,
  output logic            o_resp_valid,
  output logic [XLEN-1:0] o_result
);

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  muldiv_state_e     r_state, w_state_d;
  logic [CNT_W-1:0]  r_cnt;
  muldiv_op_e        r_op;
  logic              r_word, r_sign_a, r_sign_b;
  logic [XLEN-1:0]   r_result;

  muldiv_op_e        w_op;
  logic              w_is_mul, w_signed_a, w_signed_b, w_sext_word;
  logic [XLEN-1:0]   w_a_ext, w_b_ext, w_mag_a, w_mag_b, w_min, w_fast_res, w_load_lo;
  logic              w_sign_a, w_sign_b, w_div0, w_ovf, w_fast;
  logic              w_accept, w_step, w_finish, w_skip;
  logic [XLEN-1:0]   w_nhi, w_nlo, w_quot_c, w_rem_c, w_div_res, w_final;
  logic [2*XLEN-1:0] w_prod_c;

  // Request decode: operand extension, magnitudes and fast cases.
  always_comb begin
    w_op        = muldiv_op_e'(i_req_op);
    w_is_mul    = ~i_req_op[2];
    w_signed_a  = (w_op == OpMulh) || (w_op == OpMulhsu) || (w_op == OpDiv) || (w_op == OpRem);
    w_signed_b  = (w_op == OpMulh) || (w_op == OpDiv) || (w_op == OpRem);
    w_sext_word = (w_op == OpDiv) || (w_op == OpRem);
    w_a_ext     = i_srca;
    w_b_ext     = i_srcb;
    if (i_req_word) begin
      w_a_ext = w_sext_word ? sext32(i_srca[31:0]) : {{(XLEN-32){1'b0}}, i_srca[31:0]};
      w_b_ext = w_sext_word ? sext32(i_srcb[31:0]) : {{(XLEN-32){1'b0}}, i_srcb[31:0]};
    end
    w_sign_a  = w_signed_a & w_a_ext[XLEN-1];
    w_sign_b  = w_signed_b & w_b_ext[XLEN-1];
    w_mag_a   = w_sign_a ? -w_a_ext : w_a_ext;
    w_mag_b   = w_sign_b ? -w_b_ext : w_b_ext;
    w_min     = i_req_word ? {{(XLEN-32){1'b1}}, 1'b1, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    w_div0    = ~w_is_mul & (w_b_ext == '0);
    w_ovf     = w_sext_word & (w_a_ext == w_min) & (w_b_ext == '1);
    w_fast    = w_div0 | w_ovf;
    if (w_div0) w_fast_res = i_req_op[1] ? w_a_ext : '1;
    else        w_fast_res = i_req_op[1] ? '0 : w_a_ext;
    if (i_req_word) w_fast_res = sext32(w_fast_res[31:0]);
    // Word divides keep the dividend in the top half so 32 shifts consume it.
    w_load_lo = w_is_mul ? w_mag_b : (i_req_word ? (w_mag_a << 32) : w_mag_a);
    w_accept  = (r_state == StIdle) & i_req_valid & ~i_flush;
    w_step    = (r_state == StBusy) & ~i_flush;
    w_finish  = w_step & ((r_cnt == CNT_W'(1)) | w_skip);
  end

  muldiv_iter_dp #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_dp (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (w_accept),
    .i_load_lo   (w_load_lo),
    .i_load_opnd (w_is_mul ? w_mag_a : w_mag_b),
    .i_step      (w_step),
    .i_is_mul    (~r_op[2]),
    .i_shamt     (r_cnt),
    .o_skip      (w_skip),
    .o_next_hi   (w_nhi),
    .o_next_lo   (w_nlo)
  );

  // Final result from the last iteration's accumulator, with sign and word fix-up.
  always_comb begin
    w_prod_c  = (r_sign_a ^ r_sign_b) ? -{w_nhi, w_nlo} : {w_nhi, w_nlo};
    w_quot_c  = (r_sign_a ^ r_sign_b) ? -w_nlo : w_nlo;
    w_rem_c   = r_sign_a ? -w_nhi : w_nhi;
    w_div_res = r_op[1] ? w_rem_c : w_quot_c;
    case (r_op)
      OpMul:                     w_final = r_word ? sext32(w_prod_c[XLEN-1:XLEN-32])
                                                  : w_prod_c[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: w_final = w_prod_c[2*XLEN-1:XLEN];
      default:                   w_final = r_word ? sext32(w_div_res[31:0]) : w_div_res;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= StIdle;
    else         r_state <= w_state_d;
  end

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_d = w_fast ? StDone : StBusy;
      StBusy:  if (i_flush) w_state_d = StIdle;
               else if (w_finish) w_state_d = StDone;
      StDone:  if (i_flush || i_resp_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    o_stall_out  = i_req_valid & (r_state != StDone);
    o_resp_valid = (r_state == StDone);
    o_result     = r_result;
  end

  // Counter, latched op attributes and registered result.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt    <= '0;
      r_op     <= OpMul;
      r_word   <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_cnt    <= i_req_word ? CNT_W'(WORD_ITER) : CNT_W'(XLEN_ITER);
      r_op     <= w_op;
      r_word   <= i_req_word;
      r_sign_a <= w_sign_a;
      r_sign_b <= w_sign_b;
      if (w_fast) r_result <= w_fast_res;
    end else if (w_step) begin
      r_cnt <= w_skip ? '0 : r_cnt - CNT_W'(1);
      if (w_finish) r_result <= w_final;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with hand-computed results and latencies.
module tb_muldiv_seq;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EarlyOut = 1'b1;
`else
  localparam bit EarlyOut = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, req_valid, req_word, flush, resp_ready;
  logic [2:0]  req_op;
  logic [63:0] srca, srcb;
  logic        stall_out, resp_valid;
  logic [63:0] result;

  int n_vec = 0;
  int n_err = 0;

  muldiv_seq dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_req_valid  (req_valid),
    .i_req_op     (req_op),
    .i_req_word   (req_word),
    .i_srca       (srca),
    .i_srcb       (srcb),
    .i_flush      (flush),
    .i_resp_ready (resp_ready),
    .o_stall_out  (stall_out),
    .o_resp_valid (resp_valid),
    .o_result     (result)
  );

  always #5 clk = ~clk;

  // Execute must hold req_valid while stalled, except when flushing or once DONE.
  logic r_hold = 1'b0;
  always @(posedge clk) begin
    if (r_hold && !reset && !flush)
      assert (req_valid || resp_valid) else $error("req_valid dropped while stalled");
    r_hold <= stall_out & ~flush & ~reset;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic word,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                        input int exp_lat, input int hold);
    int lat, stalls;
    lat = 0;
    stalls = 0;
    req_valid = 1'b1; req_op = op; req_word = word; srca = a; srcb = b;
    resp_ready = (hold == 0);
    #1;
    if (stall_out) stalls++;
    while (!resp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (stall_out) stalls++;
    end
    if (!(EarlyOut && op < 3'd4)) begin
      check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check_eq({tag, " stall cycles"}, 64'(stalls), 64'(exp_lat));
    end
    check_eq({tag, " result"}, result, exp);
    req_valid = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq({tag, " held valid"}, 64'(resp_valid), 64'd1);
      check_eq({tag, " held result"}, result, exp);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check_eq({tag, " back to idle"}, 64'(resp_valid), 64'd0);
  endtask

  initial begin
    int hits;
    reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_word = 1'b0;
    srca = '0; srcb = '0; flush = 1'b0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset resp_valid", 64'(resp_valid), 64'd0);
    check_eq("reset result", result, 64'd0);
    check_eq("reset stall", 64'(stall_out), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("mul 7*-3", 3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, 0);
    run_op("mulhu", 3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
    run_op("mulhsu", 3'd2, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    run_op("divw ovf", 3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 0);
    run_op("remu by0", 3'd7, 1'b0, 64'd42, 64'd0, 64'd42, 1, 0);
    run_op("rem -7%2", 3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 65, 0);
    run_op("divuw", 3'd5, 1'b1, 64'd100, 64'd7, 64'd14, 33, 0);
    run_op("div hold", 3'd4, 1'b0, 64'd100, 64'd3, 64'd33, 65, 5);
    run_op("div by0", 3'd4, 1'b0, 64'd5, 64'd0, '1, 1, 0);
    run_op("div ovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 0);
    run_op("rem ovf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 0);
    run_op("mulw", 3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, 0);
    run_op("divw -20/3", 3'd4, 1'b1, 64'hFFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 33, 0);

    // Request with flush in IDLE is dropped; a fast op would otherwise be DONE next cycle.
    req_valid = 1'b1; req_op = 3'd7; req_word = 1'b0; srca = 64'd9; srcb = 64'd0; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    #1;
    check_eq("flush+req ignored", 64'(resp_valid), 64'd0);
    @(posedge clk); #1;
    check_eq("flush+req still idle", 64'(resp_valid), 64'd0);

    // Flush part-way through a divide.
    req_valid = 1'b1; req_op = 3'd4; req_word = 1'b0; srca = 64'd1000; srcb = 64'd7;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    #1;
    check_eq("flush resp_valid", 64'(resp_valid), 64'd0);
    check_eq("flush stall", 64'(stall_out), 64'd0);
    hits = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (resp_valid) hits++;
    end
    check_eq("flush no result", 64'(hits), 64'd0);

    run_op("mul 6*7", 3'd0, 1'b0, 64'd6, 64'd7, 64'd42, 65, 0);

    // Synchronous reset in the middle of an iteration.
    req_valid = 1'b1; req_op = 3'd4; req_word = 1'b0; srca = 64'd1000; srcb = 64'd7;
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("midreset resp_valid", 64'(resp_valid), 64'd0);
    check_eq("midreset result", result, 64'd0);
    check_eq("midreset stall", 64'(stall_out), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    run_op("after reset divw", 3'd4, 1'b1, 64'hFFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 33, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Sequencer for a shared iterative multiply/divide datapath used by the execute stage of the RV64 pipeline.
- Accepts one M-extension operation from execute and stalls execute while it iterates.
- Presents a registered result and holds it until the memory side of the pipeline is ready to accept it.
- Uses one radix-2 shift-add/restoring-subtract engine for all MUL/DIV/REM variants, including the W forms.

Parameters:
- XLEN, 64, operand and result width.
- CNT_W, 7, iteration counter width; must hold XLEN.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  execute holds a valid M-extension op; held stable while stall_out=1
- req_op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- req_word  in  1  W variant; legal only with MUL/DIV/DIVU/REM/REMU
- srca  in  XLEN  rs1 operand
- srcb  in  XLEN  rs2 operand
- flush  in  1  squash the in-flight op (branch redirect)
- resp_ready  in  1  downstream accepts; driven as ~stop_formem
- stall_out  out  1  execute must hold its instruction
- resp_valid  out  1  result is valid
- result  out  XLEN  registered result

Behaviour:
- FSM states: IDLE, BUSY, DONE.
- Reset (synchronous): go to IDLE; counter, accumulators and result are zero; resp_valid=0.
- stall_out = req_valid & (state!=DONE). It is combinational, so it asserts in the same cycle the request appears.
- IDLE, on req_valid & ~flush:
  - Latch operand magnitudes, operand signs, op and word flag.
  - Word ops use the low 32 bits, sign- or zero-extended as the op requires.
  - Set cnt = 32 if req_word, else 64.
  - Go to BUSY, unless a fast case applies; fast cases go straight to DONE.
- Fast cases (DONE one cycle after the request):
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = dividend.
  - Signed overflow (most-negative / -1): DIV = dividend; REM = 0.
  - The W forms use the 32-bit most-negative value, and the result is sign-extended.
- BUSY: one iteration per cycle, cnt decrements.
  - Multiply: 128-bit accumulator. If the multiplier LSB is 1, add the multiplicand into the upper half; then shift right by 1.
  - Divide: shift {rem,quot} left by 1. If rem >= divisor, subtract and set quotient bit 0.
  - When cnt==1, go to DONE on the next edge. Sign correction (negation) and W sign-extension happen on that same edge; result is registered.
- Latency: N+1 cycles from request to resp_valid (65 for 64-bit, 33 for W).
- DONE: resp_valid=1 and result is stable.
  - If resp_ready, go to IDLE; a new request is accepted no earlier than the next cycle.
  - If not resp_ready, hold DONE indefinitely.
- Result selection: MUL/MULW take the low product half. MULH/MULHSU/MULHU take the high half after signed correction of the 128-bit value. MULHSU treats srca as signed and srcb as unsigned.
- Flush in any state: IDLE on the next edge, resp_valid=0, and no result is produced.
- Flush and req_valid in the same cycle in IDLE: the request is ignored.
- req_valid dropping while BUSY without flush is illegal; a bench assertion flags it.

Optional Feature:
- MULDIV_EARLY_OUT_EN defined: in a multiply, when the remaining multiplier bits are all zero, shift the accumulator by cnt in one step and go to DONE next cycle. Latency is then as low as 2 cycles.
- Undefined: every multiply takes the full N iterations. Results are identical either way.

Decomposition:
- Shared package (common): the muldiv op enum (3-bit) and the constants XLEN_ITER=64 and WORD_ITER=32.
- One natural sub-module, muldiv_iter_dp: accumulator registers plus a single add/sub per cycle.
- muldiv_seq keeps the FSM, counter, fast-case detection and sign/word fix-up.

Test Plan:
- MUL a=7 b=-3, 64-bit -> stall_out for 65 cycles, result=0xFFFF_FFFF_FFFF_FFEB (-21), resp_valid with resp_ready=1 for one cycle.
- MULHU a=b=0xFFFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_FFFF_FFFE. MULHSU a=-1 b=2 -> result=0xFFFF_FFFF_FFFF_FFFF.
- DIVW a=0x8000_0000 b=0xFFFF_FFFF -> fast path, resp_valid in cycle 1, result=0xFFFF_FFFF_8000_0000. REMU b=0, a=42 -> result=42 in cycle 1.
- REM a=-7 b=2 -> result=-1 after 65 cycles. DIVUW a=100 b=7 -> result=14 after 33 cycles.
- DIV a=100 b=3 with resp_ready=0 for 5 cycles after DONE -> result=33 stays stable and resp_valid stays high; IDLE the cycle after resp_ready rises.
- Flush at iteration 10 of DIV -> IDLE next cycle, resp_valid never rises. A new MUL 6*7 issued afterwards -> 42. A synchronous reset mid-BUSY -> all outputs 0 on the next edge.
